// File: rtl/fetch_unit.sv
// Instruction fetch sequencer for a 4096x4 strobed RAM: two nibble reads per instruction, valid/ready to the decoder.
// Define FETCH_STORE_EN to include the nibble store path (ST_SU/ST_WR states, st_* port).
module fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pci,
  output logic              cs_ram,
  output logic              we_ram,
  output logic [3:0]        ram_wdata,
  input  logic [3:0]        ram_rdata,
  output logic [7:0]        instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [3:0]        st_data,
  output logic              st_ack
);

`ifdef FETCH_STORE_EN
  typedef enum logic [2:0] {IDLE, SU_OP, RD_OP, SU_ARG, RD_ARG, HOLD, ST_SU, ST_WR} state_t;
`else
  typedef enum logic [2:0] {IDLE, SU_OP, RD_OP, SU_ARG, RD_ARG, HOLD} state_t;
`endif

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] pci_reg, pci_next;
  logic              cs_reg, cs_next;
  logic [3:0]        opcode_reg, opcode_next;
  logic [7:0]        instr_reg, instr_next;
  logic              valid_reg, valid_next;
  logic              store_go;

`ifdef FETCH_STORE_EN
  logic              we_reg, we_next;
  logic [3:0]        wdata_reg, wdata_next;
  logic              ack_reg, ack_next;

  // A request still held during its own ack cycle must not start a second write.
  assign store_go = st_req && !ack_reg;
`else
  assign store_go = 1'b0;
  logic unused_store;
  assign unused_store = ^{st_req, st_addr, st_data};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      pci_reg    <= '0;
      cs_reg     <= 1'b0;
      opcode_reg <= 4'h0;
      instr_reg  <= 8'h00;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      pci_reg    <= pci_next;
      cs_reg     <= cs_next;
      opcode_reg <= opcode_next;
      instr_reg  <= instr_next;
      valid_reg  <= valid_next;
    end
  end

`ifdef FETCH_STORE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_reg    <= 1'b0;
      wdata_reg <= 4'h0;
      ack_reg   <= 1'b0;
    end else begin
      we_reg    <= we_next;
      wdata_reg <= wdata_next;
      ack_reg   <= ack_next;
    end
  end
`endif

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    pci_next    = pci_reg;
    cs_next     = 1'b0;
    opcode_next = opcode_reg;
    instr_next  = instr_reg;
    valid_next  = valid_reg;
`ifdef FETCH_STORE_EN
    we_next     = 1'b0;
    wdata_next  = wdata_reg;
    ack_next    = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (jump)          pc_next    = jump_addr;
        else if (store_go) begin
`ifdef FETCH_STORE_EN
          state_next = ST_SU;
`endif
        end
        else if (enable)   state_next = SU_OP;
      end
      SU_OP, SU_ARG: begin
        if (jump) begin
          pc_next    = jump_addr;
          state_next = IDLE;
        end else begin
          state_next = (state_reg == SU_OP) ? RD_OP : RD_ARG;
        end
      end
      RD_OP: begin
        if (jump) begin
          pc_next    = jump_addr;
          state_next = IDLE;
        end else begin
          opcode_next = ram_rdata;
          state_next  = SU_ARG;
        end
      end
      RD_ARG: begin
        if (jump) begin
          pc_next    = jump_addr;
          state_next = IDLE;
        end else begin
          instr_next = {opcode_reg, ram_rdata};
          valid_next = 1'b1;
          pc_next    = pc_reg + ADDR_W'(2);
          state_next = HOLD;
        end
      end
      HOLD: begin
        // A jump discards the held instruction, but a same-cycle ready still consumed it.
        if (jump) begin
          valid_next = 1'b0;
          pc_next    = jump_addr;
          state_next = IDLE;
        end else if (instr_ready) begin
          valid_next = 1'b0;
          if (store_go) begin
`ifdef FETCH_STORE_EN
            state_next = ST_SU;
`endif
          end
          else if (enable) state_next = SU_OP;
          else             state_next = IDLE;
        end
      end
`ifdef FETCH_STORE_EN
      ST_SU: begin
        if (jump) pc_next = jump_addr;
        state_next = ST_WR;
      end
      ST_WR: begin
        if (jump) pc_next = jump_addr;
        ack_next   = 1'b1;
        state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase

    // Bus outputs are registered from the state being entered so they are stable for the whole cycle.
    case (state_next)
      SU_OP:         pci_next = pc_reg;
      SU_ARG:        pci_next = pc_reg + ADDR_W'(1);
      RD_OP, RD_ARG: cs_next  = 1'b1;
`ifdef FETCH_STORE_EN
      ST_SU: begin
        pci_next   = st_addr;
        wdata_next = st_data;
        we_next    = 1'b1;
      end
      ST_WR: begin
        cs_next = 1'b1;
        we_next = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign pc          = pc_reg;
  assign pci         = pci_reg;
  assign cs_ram      = cs_reg;
  assign instr       = instr_reg;
  assign instr_valid = valid_reg;

`ifdef FETCH_STORE_EN
  assign we_ram    = we_reg;
  assign ram_wdata = wdata_reg;
  assign st_ack    = ack_reg;
`else
  assign we_ram    = 1'b0;
  assign ram_wdata = 4'h0;
  assign st_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cycle sequences, a vector table and a randomized run against a fetch model.
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, enable, jump, instr_ready, st_req;
  logic [11:0] jump_addr, st_addr, pci, pc;
  logic [3:0]  st_data, ram_wdata, ram_rdata;
  logic        cs_ram, we_ram, instr_valid, st_ack;
  logic [7:0]  instr;

  logic [3:0]  mem [0:4095];
  assign ram_rdata = mem[pci];
  always @(posedge cs_ram) if (we_ram) mem[pci] <= ram_wdata;

  fetch_unit #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .jump(jump), .jump_addr(jump_addr),
    .pci(pci), .cs_ram(cs_ram), .we_ram(we_ram), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack));

  // Second instance exercising the wrap from a reset PC of FFF.
  logic        enable2;
  logic [11:0] pci2, pc2;
  logic [3:0]  wdata2, rdata2;
  logic        cs2, we2, valid2, ack2;
  logic [7:0]  instr2;
  assign rdata2 = (pci2 == 12'hFFF) ? 4'h7 : (pci2 == 12'h000) ? 4'h1 : 4'h0;

  fetch_unit #(.ADDR_W(12), .RESET_PC(12'hFFF)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .enable(enable2), .jump(1'b0), .jump_addr(12'h000),
    .pci(pci2), .cs_ram(cs2), .we_ram(we2), .ram_wdata(wdata2), .ram_rdata(rdata2),
    .instr(instr2), .instr_valid(valid2), .instr_ready(1'b0), .pc(pc2),
    .st_req(1'b0), .st_addr(12'h000), .st_data(4'h0), .st_ack(ack2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; enable = 1'b0; jump = 1'b0; jump_addr = 12'h000;
    instr_ready = 1'b0; st_req = 1'b0; st_addr = 12'h000; st_data = 4'h0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !instr_valid; i++) tick();
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [3:0]  op;
    logic [3:0]  arg;
    logic [7:0]  exp_instr;
    logic [11:0] exp_pc;
  } vec_t;
  vec_t vecs [6];

  logic        cs_hist [1:9];
  logic        valid_hist [1:9];
  logic [11:0] pci_hist [1:9];

  initial begin
    vecs[0] = '{12'h005, 4'h1, 4'h2, 8'h12, 12'h007};
    vecs[1] = '{12'h7FE, 4'h4, 4'h5, 8'h45, 12'h800};
    vecs[2] = '{12'hFFE, 4'h6, 4'h8, 8'h68, 12'h000};
    vecs[3] = '{12'hFFF, 4'hB, 4'hD, 8'hBD, 12'h001};
    vecs[4] = '{12'h0AB, 4'hE, 4'hF, 8'hEF, 12'h0AD};
    vecs[5] = '{12'h123, 4'h0, 4'h9, 8'h09, 12'h125};

    for (int i = 0; i < 4096; i++) mem[i] <= 4'h0;
    enable2 = 1'b0;
    reset_n = 1'b0; enable = 1'b0; jump = 1'b0; jump_addr = 12'h000;
    instr_ready = 1'b0; st_req = 1'b0; st_addr = 12'h000; st_data = 4'h0;
    #12;
    chk("reset_pc", 32'(pc), 32'h000);
    chk("reset_pci", 32'(pci), 32'h000);
    chk("reset_cs", 32'(cs_ram), 0);
    chk("reset_we", 32'(we_ram), 0);
    chk("reset_wdata", 32'(ram_wdata), 0);
    chk("reset_instr", 32'(instr), 0);
    chk("reset_valid", 32'(instr_valid), 0);
    chk("reset_ack", 32'(st_ack), 0);
    chk("reset_pc_wrap", 32'(pc2), 32'hFFF);

    // Wrap instance: opcode at FFF, operand at 000.
    mem[0] <= 4'hA; mem[1] <= 4'h3;
    apply_reset();
    enable2 = 1'b1;
    for (int i = 0; i < 20 && !valid2; i++) tick();
    chk("wrap_valid", 32'(valid2), 1);
    chk("wrap_instr", 32'(instr2), 32'h71);
    chk("wrap_pc", 32'(pc2), 32'h001);
    enable2 = 1'b0;

    // Basic fetch latency and strobe timing, then reset during the second RD_ARG.
    apply_reset();
    enable = 1'b1; instr_ready = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      cs_hist[c] = cs_ram; valid_hist[c] = instr_valid; pci_hist[c] = pci;
      if (c == 5) begin
        chk("basic_instr", 32'(instr), 32'hA3);
        chk("basic_pc", 32'(pc), 32'h002);
      end
    end
    chk("basic_pci_op", 32'(pci_hist[1]), 32'h000);
    chk("basic_pci_arg", 32'(pci_hist[3]), 32'h001);
    chk("basic_cs_pattern", {27'd0, cs_hist[1], cs_hist[2], cs_hist[3], cs_hist[4], cs_hist[5]}, 32'b01010);
    chk("basic_valid_c4", 32'(valid_hist[4]), 0);
    chk("basic_valid_c5", 32'(valid_hist[5]), 1);
    chk("basic_cs_c9", 32'(cs_hist[9]), 1);
    reset_n = 1'b0;
    #1;
    chk("midreset_cs", 32'(cs_ram), 0);
    chk("midreset_pc", 32'(pc), 32'h000);
    chk("midreset_pci", 32'(pci), 32'h000);
    chk("midreset_instr", 32'(instr), 0);
    chk("midreset_valid", 32'(instr_valid), 0);

    // Jump during RD_OP aborts the access and refetches from the target.
    mem[12'h100] <= 4'h5; mem[12'h101] <= 4'hC;
    apply_reset();
    enable = 1'b1; instr_ready = 1'b1;
    tick(); tick();
    chk("jmp_in_rdop", 32'(cs_ram), 1);
    jump = 1'b1; jump_addr = 12'h100;
    tick();
    jump = 1'b0;
    chk("jmp_cs_drop", 32'(cs_ram), 0);
    chk("jmp_no_valid", 32'(instr_valid), 0);
    chk("jmp_pc", 32'(pc), 32'h100);
    tick();
    chk("jmp_pci", 32'(pci), 32'h100);
    wait_valid(10);
    chk("jmp_valid", 32'(instr_valid), 1);
    chk("jmp_instr", 32'(instr), 32'h5C);
    chk("jmp_pc_after", 32'(pc), 32'h102);

    // Stall in HOLD for 10 cycles.
    apply_reset();
    enable = 1'b1; instr_ready = 1'b0;
    wait_valid(10);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 32'(instr_valid), 1);
      chk("hold_instr", 32'(instr), 32'hA3);
      chk("hold_cs", 32'(cs_ram), 0);
      chk("hold_pc", 32'(pc), 32'h002);
    end
    enable = 1'b0; instr_ready = 1'b1;
    tick();
    chk("hold_release", 32'(instr_valid), 0);

`ifdef FETCH_STORE_EN
    apply_reset();
    st_req = 1'b1; st_addr = 12'h020; st_data = 4'h9;
    tick();
    chk("st_c1_we", 32'(we_ram), 1);
    chk("st_c1_cs", 32'(cs_ram), 0);
    chk("st_c1_pci", 32'(pci), 32'h020);
    chk("st_c1_wdata", 32'(ram_wdata), 32'h9);
    chk("st_c1_ack", 32'(st_ack), 0);
    tick();
    chk("st_c2_cs", 32'(cs_ram), 1);
    chk("st_c2_we", 32'(we_ram), 1);
    chk("st_c2_ack", 32'(st_ack), 0);
    tick();
    chk("st_c3_ack", 32'(st_ack), 1);
    chk("st_c3_cs", 32'(cs_ram), 0);
    st_req = 1'b0;
    tick();
    chk("st_c4_ack", 32'(st_ack), 0);
    chk("st_c4_we", 32'(we_ram), 0);
    chk("st_mem", 32'(mem[12'h020]), 32'h9);
    jump = 1'b1; jump_addr = 12'h020;
    tick();
    jump = 1'b0; enable = 1'b1;
    wait_valid(10);
    chk("st_fetch_op", 32'(instr[7:4]), 32'h9);
    enable = 1'b0;
    tick();
`else
    apply_reset();
    st_req = 1'b1; st_addr = 12'h020; st_data = 4'h9;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("nost_we", 32'(we_ram), 0);
      chk("nost_ack", 32'(st_ack), 0);
      chk("nost_cs", 32'(cs_ram), 0);
      chk("nost_wdata", 32'(ram_wdata), 0);
    end
    st_req = 1'b0;
`endif

    // Vector table: jump to each address from IDLE and fetch one instruction.
    foreach (vecs[v]) begin
      logic [11:0] a1;
      a1 = vecs[v].addr + 12'd1;
      mem[vecs[v].addr] <= vecs[v].op;
      mem[a1] <= vecs[v].arg;
      apply_reset();
      jump = 1'b1; jump_addr = vecs[v].addr;
      tick();
      jump = 1'b0; enable = 1'b1; instr_ready = 1'b1;
      wait_valid(10);
      chk("vec_valid", 32'(instr_valid), 1);
      chk("vec_instr", 32'(instr), 32'(vecs[v].exp_instr));
      chk("vec_pc", 32'(pc), 32'(vecs[v].exp_pc));
      enable = 1'b0;
      tick();
    end

    // Randomized run: every accepted instruction must come from the model's expected address.
    begin
      logic [11:0] exp_addr, a1;
      logic        prev_cs, prev_hold;
      logic [7:0]  prev_instr;
      int          n_acc;
      for (int i = 0; i < 4096; i++) mem[i] <= 4'($urandom);
      apply_reset();
      exp_addr = 12'h000; prev_cs = 1'b0; prev_hold = 1'b0; prev_instr = 8'h00; n_acc = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (cs_ram) chk("rand_cs_gap", 32'(prev_cs), 0);
        if (prev_hold) begin
          chk("rand_hold_valid", 32'(instr_valid), 1);
          chk("rand_hold_instr", 32'(instr), 32'(prev_instr));
        end
        enable      = ($urandom_range(0, 9) < 8);
        instr_ready = 1'($urandom_range(0, 1));
        jump        = ($urandom_range(0, 31) == 0);
        jump_addr   = 12'($urandom);
        if (instr_valid && instr_ready) begin
          a1 = exp_addr + 12'd1;
          chk("rand_instr", 32'(instr), 32'({mem[exp_addr], mem[a1]}));
          chk("rand_pc", 32'(pc), 32'(exp_addr + 12'd2));
          exp_addr = exp_addr + 12'd2;
          n_acc++;
        end
        if (jump) exp_addr = jump_addr;
        prev_hold  = instr_valid && !instr_ready && !jump;
        prev_instr = instr;
        prev_cs    = cs_ram;
        tick();
      end
      chk("rand_progress", 32'(n_acc > 100), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer sitting directly upstream of the 4096×4 program/data RAM. Owns the 12-bit program counter, drives the RAM address, chip-select and write-enable with a strobe protocol, reads two consecutive nibbles (opcode, operand) and presents them to the decoder as one 8-bit instruction over a valid/ready handshake. An optional store port lets the core write nibbles into the RAM through the same sequencer.

## Interface
- ADDR_W, 12, RAM address width / PC width
- RESET_PC, 12'h000, PC value loaded on reset
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  allows new fetches to start
- jump  in  1  load PC from jump_addr (one-cycle pulse)
- jump_addr  in  12  jump target
- pci  out  12  RAM address
- cs_ram  out  1  RAM chip select, strobe
- we_ram  out  1  RAM write enable
- ram_wdata  out  4  write nibble to RAM
- ram_rdata  in  4  read nibble from RAM data bus
- instr  out  8  {opcode, operand}
- instr_valid  out  1  instr holds a complete instruction
- instr_ready  in  1  decoder accepts instr
- pc  out  12  address of the next opcode to fetch
- st_req, st_addr[11:0], st_data[3:0]  in  store request, held until st_ack
- st_ack  out  1  one-cycle pulse: store written

## Operation
- States: IDLE, SU_OP, RD_OP, SU_ARG, RD_ARG, HOLD, ST_SU, ST_WR.
- Each RAM access = two cycles: SU (pci driven, cs_ram=0) then strobe (cs_ram=1); the RAM only responds to cs edges, so cs_ram must return to 0 between accesses.
- IDLE: st_req → ST_SU; else enable → SU_OP; else stay.
- SU_OP: pci=pc. RD_OP: cs_ram=1, we_ram=0; opcode ← ram_rdata at end of cycle.
- SU_ARG: pci=pc+1 (mod 4096). RD_ARG: strobe; operand captured; pc ← pc+2 (mod 4096).
- HOLD: instr_valid=1, instr stable. On instr_ready: st_req → ST_SU; else enable → SU_OP; else IDLE.
- ST_SU: pci=st_addr, ram_wdata=st_data, we_ram=1, cs_ram=0. ST_WR: cs_ram=1, we_ram=1; st_ack pulses the following cycle; next state IDLE.
- Priority: jump > store > fetch.
- jump in any fetch state (SU_OP..RD_ARG): access aborted, cs_ram=0 next cycle, partial nibbles discarded, pc ← jump_addr, go IDLE.
- jump in HOLD: instr_valid drops; a same-cycle instr_ready still counts as accepted; pc ← jump_addr.
- jump during ST_SU/ST_WR: store completes; pc ← jump_addr.
- enable low never aborts an access in progress; it only blocks new fetches.
- Wrap: pc=12'hFFF fetches opcode @FFF, operand @000, pc → 12'h001.

## Timing
- Reset (async, reset_n=0): state IDLE, pc=RESET_PC, pci=0, cs_ram=0, we_ram=0, ram_wdata=0, instr=0, instr_valid=0, st_ack=0.
- All outputs registered; pci/we_ram/ram_wdata stable for the full SU and strobe cycles.
- Fetch latency: enable seen in IDLE at edge 0 → instr_valid high after edge 5.
- Back-to-back throughput (instr_ready held 1): one instruction per 5 cycles.
- Store: ST_SU → ST_WR → st_ack high one cycle → IDLE; 3 cycles from acceptance.
- instr and instr_valid change only at HOLD entry/exit.

## Configuration
- FETCH_STORE_EN defined: store path, ST_SU/ST_WR states as above.
- Undefined: store states absent, st_* inputs ignored, st_ack=0, we_ram=0, ram_wdata=0 constantly.

## Test plan
- Reset mid-fetch (reset_n low during RD_ARG) → all outputs at reset values immediately, pc=RESET_PC, cs_ram=0.
- RAM[000]=4'hA, RAM[001]=4'h3, enable=1, instr_ready=1 → instr=8'hA3 valid at cycle 5, pc=12'h002, cs_ram pulses at cycles 2 and 4.
- RESET_PC=12'hFFF, RAM[FFF]=4'h7, RAM[000]=4'h1 → instr=8'h71, pc=12'h001.
- jump=1, jump_addr=12'h100 during RD_OP → cs_ram=0 next cycle, no instr_valid, next fetch reads pci=12'h100.
- instr_ready=0 for 10 cycles in HOLD → instr stable, cs_ram=0 throughout, pc unchanged.
- FETCH_STORE_EN: st_req with st_addr=12'h020, st_data=4'h9 in IDLE → we_ram=1, cs_ram strobe, st_ack pulse at cycle 3; subsequent fetch of 12'h020 returns opcode 4'h9.
